qspi_slave_ram: RTL and testbench

Quad-SPI slave front end that lets an external host load operand/operator bytes into the shared byte RAM and read result bytes back out of it. It sits directly upstream of the FPU sequencer on the same RAM, which reads bytes 0x00–0x0F and writes results to 0x10–0x1F. The block runs entirely in the system clock domain and oversamples the QSPI pins. It converts nibble-serial QSPI transfers into single-cycle RAM write strobes and synchronous RAM reads.

---
 rtl/qspi_slave_ram.sv | 146 ++++++++++++++
 tb/tb_qspi_slave_ram.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/qspi_slave_ram.sv
// rtl/qspi_slave_ram.sv - QSPI slave front end to a shared byte RAM
// Oversamples sclk/cs_n/io_in in the clk domain; writes (0x38) and reads (0xEB) the RAM.
module qspi_slave_ram #(
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic [3:0]            io_in,
  output logic [3:0]            io_out,
  output logic                  io_oe,
  output logic [addr_width-1:0] addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  wen,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE} state_t;

  state_t      state;
  logic [2:0]  sclk_sync;
  logic [2:0]  cs_sync;
  logic [3:0]  io_m;
  logic [3:0]  io_s;
  logic        nib;
  logic [3:0]  hi;
  logic        is_read;
  logic [7:0]  tx;
  logic [1:0]  fetch;
  logic        inc_addr;
  logic        out_nib;

  logic       rise_ev;
  logic       fall_ev;
  logic       cs_fall;
  logic       byte_done;
  logic [7:0] full_byte;

  // Index 2 is the delayed copy used only for edge detection.
  assign rise_ev   = sclk_sync[1] & ~sclk_sync[2];
  assign fall_ev   = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign byte_done = rise_ev & nib;
  assign full_byte = {hi, io_s};

  // cs_n sync resets low so a host already selected at reset release never looks like a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sclk_sync <= '0;
      cs_sync   <= '0;
      io_m      <= '0;
      io_s      <= '0;
      nib       <= 1'b0;
      hi        <= '0;
      is_read   <= 1'b0;
      tx        <= '0;
      fetch     <= '0;
      inc_addr  <= 1'b0;
      out_nib   <= 1'b0;
      io_out    <= '0;
      io_oe     <= 1'b0;
      addr      <= '0;
      data_out  <= '0;
      wen       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[1:0], cs_n};
      io_m      <= io_in;
      io_s      <= io_m;
      wen       <= 1'b0;
      inc_addr  <= 1'b0;
      if (inc_addr)
        addr <= addr + 1'b1;
      // RAM read data is valid one clk after addr, so capture two clks after addr is set.
      fetch <= {fetch[0], 1'b0};
      if (fetch[1])
        tx <= data_in;

      if (cs_sync[1]) begin
        state <= IDLE;
        io_oe <= 1'b0;
        busy  <= 1'b0;
        nib   <= 1'b0;
      end else if (cs_fall) begin
        state   <= CMD;
        busy    <= 1'b1;
        nib     <= 1'b0;
        hi      <= '0;
        tx      <= '0;
        out_nib <= 1'b0;
      end else begin
        if (rise_ev && (state inside {CMD, ADDR, DUMMY, WDATA})) begin
          if (!nib)
            hi <= io_s;
          nib <= ~nib;
        end
        case (state)
          CMD: if (byte_done) begin
            if (full_byte == 8'h38) begin
              state   <= ADDR;
              is_read <= 1'b0;
            end else if (full_byte == 8'hEB) begin
              state   <= ADDR;
              is_read <= 1'b1;
            end else begin
              state <= IGNORE;
            end
          end
          ADDR: if (byte_done) begin
            addr <= full_byte;
            if (is_read) begin
              fetch <= 2'b01;
              state <= DUMMY;
            end else begin
              state <= WDATA;
            end
          end
          DUMMY: if (byte_done)
            state <= RDATA;
          WDATA: if (byte_done) begin
            data_out <= full_byte;
            wen      <= 1'b1;
            inc_addr <= 1'b1;
          end
          RDATA: if (fall_ev) begin
            io_oe   <= 1'b1;
            out_nib <= ~out_nib;
            if (!out_nib) begin
              io_out <= tx[7:4];
            end else begin
              io_out <= tx[3:0];
              addr   <= addr + 1'b1;
              fetch  <= 2'b01;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_slave_ram.sv
// tb/tb_qspi_slave_ram.sv - directed self-checking bench for qspi_slave_ram
module tb_qspi_slave_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out;
  logic       io_oe;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       wen;
  logic       busy;

  qspi_slave_ram #(.addr_width(8)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .addr(addr), .data_in(data_in),
    .data_out(data_out), .wen(wen), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (wen) mem[addr] <= data_out;
    data_in <= mem[addr];
  end

  logic [15:0] wlog[$];
  int          b2b = 0;
  int          oe_cnt = 0;
  logic        prev_wen = 1'b0;
  always @(negedge clk) begin
    if (wen) wlog.push_back({addr, data_out});
    if (wen && prev_wen) b2b++;
    prev_wen = wen;
    if (io_oe) oe_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nib(input logic [3:0] n);
    @(negedge clk) io_in = n;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic rnib(input string nm, input logic [3:0] exp);
    repeat (5) @(negedge clk);
    check({nm, "_oe"}, io_oe, 1'b1);
    check(nm, io_out, exp);
    sclk = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic cs_start();
    @(negedge clk) cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d[$]);
    cs_start();
    send_byte(8'h38);
    send_byte(a);
    foreach (d[i]) send_byte(d[i]);
    cs_end();
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_wr [19];
  int  oe_before;

  initial begin
    exp_wr = '{
      '{8'h00, 8'h3F}, '{8'h01, 8'h80}, '{8'h02, 8'h00}, '{8'h03, 8'h00},
      '{8'h04, 8'h40}, '{8'h05, 8'h00}, '{8'h06, 8'h00}, '{8'h07, 8'h00},
      '{8'h08, 8'h01},
      '{8'hFE, 8'hAA}, '{8'hFF, 8'hBB}, '{8'h00, 8'hCC},
      '{8'h40, 8'h11}, '{8'h50, 8'h77},
      '{8'h10, 8'h40}, '{8'h11, 8'h40}, '{8'h12, 8'h00}, '{8'h13, 8'h00},
      '{8'h20, 8'h5C}
    };

    repeat (3) @(negedge clk);
    check("rst_io_oe", io_oe, 1'b0);
    check("rst_wen", wen, 1'b0);
    check("rst_addr", addr, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_io_out", io_out, 4'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Operands A=1.0, B=2.0, op=0x01
    wr_frame(8'h00, '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01});
    for (int i = 0; i < 9; i++) check($sformatf("mem_%0d", i), mem[i], exp_wr[i].d);

    wr_frame(8'hFE, '{8'hAA, 8'hBB, 8'hCC});

    // Abort after one nibble of the second data byte
    cs_start();
    send_byte(8'h38);
    send_byte(8'h40);
    send_byte(8'h11);
    nib(4'h2);
    cs_end();
    wr_frame(8'h50, '{8'h77});

    // Unknown command: busy tracks cs_n, no output enable
    oe_before = oe_cnt;
    cs_start();
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_byte(8'h12 + 8'(i));
    check("ign_busy_hi", busy, 1'b1);
    cs_end();
    check("ign_busy_lo", busy, 1'b0);
    check("ign_oe", oe_cnt - oe_before, 0);

    wr_frame(8'h10, '{8'h40, 8'h40, 8'h00, 8'h00});

    // Read frame with busy/io_oe latency checks
    @(negedge clk) cs_n = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_rise_early", busy, 1'b0);
    @(negedge clk);
    check("busy_rise", busy, 1'b1);
    repeat (3) @(negedge clk);
    send_byte(8'hEB);
    send_byte(8'h10);
    nib(4'h0);
    check("dummy_oe", io_oe, 1'b0);
    nib(4'h0);
    rnib("rd0", 4'h4); rnib("rd1", 4'h0); rnib("rd2", 4'h4); rnib("rd3", 4'h0);
    rnib("rd4", 4'h0); rnib("rd5", 4'h0); rnib("rd6", 4'h0); rnib("rd7", 4'h0);
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("oe_fall_early", io_oe, 1'b1);
    @(negedge clk);
    check("oe_fall", io_oe, 1'b0);
    check("busy_fall", busy, 1'b0);
    repeat (10) @(negedge clk);

    // Reset during read data phase
    cs_start();
    send_byte(8'hEB);
    send_byte(8'h10);
    send_byte(8'h00);
    rnib("rr0", 4'h4);
    rnib("rr1", 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_oe", io_oe, 1'b0);
    check("rst_mid_wen", wen, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    wr_frame(8'h20, '{8'h5C});
    check("mem_20", mem[8'h20], 8'h5C);

    check("wen_count", wlog.size(), 19);
    for (int i = 0; i < 19 && i < wlog.size(); i++) begin
      check($sformatf("wen%0d_addr", i), wlog[i][15:8], exp_wr[i].a);
      check($sformatf("wen%0d_data", i), wlog[i][7:0], exp_wr[i].d);
    end
    check("wen_b2b", b2b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
